mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 161 ++++++++++++++++
 tb/tb_mem_responder.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
//   Single-outstanding memory slave with a word-addressed data RAM. A request
//   is latched when it is accepted in IDLE. An in-range request then spends
//   WAIT_CYCLES cycles in WAIT and one cycle in ACCESS, where the RAM is
//   written or read. A misaligned or out-of-range request skips straight to
//   RESP with an error flag. Each accepted request gets exactly one response
//   strobe.
//
// Parameters
//   DEPTH        data RAM size in 32-bit words (power of two, 16..4096)
//   WAIT_CYCLES  wait states inserted before each in-range access (0..15)
//
// Ports
//   clk        single clock, rising edge
//   rst        synchronous active-high reset (RAM contents are kept)
//   req_valid  request present
//   req_we     1 = store, 0 = load
//   req_addr   byte address; must be word aligned
//   req_wdata  store data, little-endian byte lanes
//   req_be     store byte enables, bit i enables byte lane i
//   req_ready  request can be accepted this cycle
//   rsp_valid  one-cycle response strobe
//   rsp_rdata  load data; zero for stores, errors and outside the strobe
//   rsp_err    request was misaligned or out of range (with rsp_valid)
//   busy       a request is in flight
// ---------------------------------------------------------------------------
module mem_responder #(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int AW = $clog2(DEPTH);
    // The counter starts at WAIT_CYCLES-1 so that WAIT lasts exactly
    // WAIT_CYCLES cycles: the cycle in which it reads 0 is the last one.
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t          r_state;
    logic [3:0]      r_cnt;
    logic            r_rsp_valid;
    logic            r_rsp_err;
    logic            r_we;
    logic [AW-1:0]   r_idx;
    logic [31:0]     r_wdata;
    logic [3:0]      r_be;
    logic [31:0]     r_ram_dout;

    // Data RAM. Powers up cleared and is deliberately untouched by rst.
    logic [31:0]     r_mem [DEPTH] = '{default: 32'h0};

    logic            w_req_err;

    // Misaligned, or word index beyond the end of the RAM.
    assign w_req_err = (req_addr[1:0] != 2'b00) || (req_addr[31:2] >= 30'(DEPTH));

    // Ready is held low for as long as reset is asserted, so nothing can be
    // accepted on an edge that reset overrides anyway.
    assign req_ready = (r_state == S_IDLE) && !rst;
    assign busy      = (r_state != S_IDLE);
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    // The RAM output register is only meaningful for an in-range load; every
    // other case, and every cycle outside the strobe, reads as zero.
    assign rsp_rdata = (r_rsp_valid && !r_rsp_err && !r_we) ? r_ram_dout : 32'h0;

    // Control FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_we        <= 1'b0;
            r_idx       <= '0;
            r_wdata     <= 32'h0;
            r_be        <= 4'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_rsp_valid <= 1'b0;
                    r_rsp_err   <= 1'b0;
                    if (req_valid) begin
                        r_we    <= req_we;
                        r_idx   <= req_addr[AW+1:2];
                        r_wdata <= req_wdata;
                        r_be    <= req_be;
                        if (w_req_err) begin
                            r_state     <= S_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                        end else if (WAIT_CYCLES == 0) begin
                            r_state <= S_ACCESS;
                        end else begin
                            r_state <= S_WAIT;
                            r_cnt   <= WAIT_LOAD;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= S_ACCESS;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_ACCESS: begin
                    r_state     <= S_RESP;
                    r_rsp_valid <= 1'b1;
                    r_rsp_err   <= 1'b0;
                end
                S_RESP: begin
                    r_state     <= S_IDLE;
                    r_rsp_valid <= 1'b0;
                    r_rsp_err   <= 1'b0;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_rsp_valid <= 1'b0;
                    r_rsp_err   <= 1'b0;
                end
            endcase
        end
    end

    // RAM port: byte-lane write or registered read, only in ACCESS. Reset acts
    // as a write inhibit so a store aborted at the end of ACCESS has no effect.
    always_ff @(posedge clk) begin
        if (!rst && (r_state == S_ACCESS)) begin
            if (r_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (r_be[b]) begin
                        r_mem[r_idx][8*b +: 8] <= r_wdata[8*b +: 8];
                    end
                end
            end else begin
                r_ram_dout <= r_mem[r_idx];
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;

    // DUT with WAIT_CYCLES=2, DEPTH=256
    logic        req_valid, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;
    logic        req_ready, rsp_valid, rsp_err, busy;
    logic [31:0] rsp_rdata;

    // DUT with WAIT_CYCLES=0, DEPTH=16 (throughput check)
    logic        z_req_valid, z_req_we;
    logic [31:0] z_req_addr, z_req_wdata;
    logic [3:0]  z_req_be;
    logic        z_req_ready, z_rsp_valid, z_rsp_err, z_busy;
    logic [31:0] z_rsp_rdata;

    mem_responder #(.DEPTH(256), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_be(req_be), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .busy(busy)
    );

    mem_responder #(.DEPTH(16), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(z_req_valid), .req_we(z_req_we), .req_addr(z_req_addr),
        .req_wdata(z_req_wdata), .req_be(z_req_be), .req_ready(z_req_ready),
        .rsp_valid(z_rsp_valid), .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err),
        .busy(z_busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference memory: 256 words, all zero at start.
    logic [31:0] model_mem [256];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic addr_is_err(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a[31:2] >= 30'd256);
    endfunction

    // One complete transaction on the WAIT_CYCLES=2 instance, checked against
    // the reference model; returns the observed load data.
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input string tag, output logic [31:0] got_rdata);
        logic        exp_err;
        int          exp_lat;
        logic [31:0] exp_rdata;
        int          lat;
        logic        got_err;
        exp_err   = addr_is_err(addr);
        exp_lat   = exp_err ? 1 : 4;
        exp_rdata = (exp_err || we) ? 32'h0 : model_mem[addr[9:2]];
        got_rdata = 32'hxxxxxxxx;
        got_err   = 1'bx;

        @(negedge clk);
        check({tag, ".ready_idle"}, {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        @(posedge clk);
        #1;
        // Scramble the request bus: the latched copy must be used.
        req_valid = 1'b0;
        req_we    = 1'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_be    = 4'($urandom);

        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1) begin
                check({tag, ".busy"}, {31'b0, busy}, 32'd1);
                check({tag, ".ready_busy"}, {31'b0, req_ready}, 32'd0);
            end
            if (rsp_valid === 1'b1) begin
                lat       = i;
                got_rdata = rsp_rdata;
                got_err   = rsp_err;
                break;
            end
        end
        check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        check({tag, ".err"}, {31'b0, got_err}, {31'b0, exp_err});
        check({tag, ".rdata"}, got_rdata, exp_rdata);

        @(negedge clk);
        check({tag, ".strobe_end"}, {31'b0, rsp_valid}, 32'd0);
        check({tag, ".rdata_idle"}, rsp_rdata, 32'h0);
        check({tag, ".ready_back"}, {31'b0, req_ready}, 32'd1);

        if (!exp_err && we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) model_mem[addr[9:2]][8*b +: 8] = wdata[8*b +: 8];
            end
        end
        $display("[TB] %s we=%0d addr=%h wdata=%h be=%h -> err=%0d rdata=%h lat=%0d",
                 tag, we, addr, wdata, be, got_err, got_rdata, lat);
    endtask

    // Store that is aborted by a one-cycle reset pulse asserted in cycle k
    // after the accept edge (k=1: WAIT, k=3: ACCESS). The model is untouched.
    task automatic abort_store(input logic [31:0] addr, input logic [31:0] wdata,
                               input int k, input string tag);
        int seen;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = 4'hF;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        seen = 0;
        for (int i = 1; i <= k; i++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) seen++;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check({tag, ".ready_after_rst"}, {31'b0, req_ready}, 32'd1);
        check({tag, ".busy_after_rst"}, {31'b0, busy}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) seen++;
        end
        check({tag, ".no_rsp"}, 32'(seen), 32'd0);
        $display("[TB] %s aborted store addr=%h wdata=%h rst_cycle=%0d responses=%0d",
                 tag, addr, wdata, k, seen);
    endtask

    logic [31:0] rd;

    initial begin
        for (int i = 0; i < 256; i++) model_mem[i] = 32'h0;
        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; req_be = 4'h0;
        z_req_valid = 1'b0; z_req_we = 1'b0; z_req_addr = 32'h0; z_req_wdata = 32'h0; z_req_be = 4'h0;

        // Reset behaviour
        repeat (3) @(negedge clk);
        check("rst.ready_low", {31'b0, req_ready}, 32'd0);
        check("rst.z_ready_low", {31'b0, z_req_ready}, 32'd0);
        rst = 1'b0;
        #1;
        check("rst.ready_first", {31'b0, req_ready}, 32'd1);
        check("rst.rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst.rsp_err", {31'b0, rsp_err}, 32'd0);
        check("rst.rsp_rdata", rsp_rdata, 32'h0);
        check("rst.busy", {31'b0, busy}, 32'd0);

        // Full-word store then load
        do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, "st_deadbeef", rd);
        do_req(1'b0, 32'h10, 32'h0, 4'h0, "ld_deadbeef", rd);
        check("ld_deadbeef.value", rd, 32'hDEADBEEF);

        // Single byte lane
        do_req(1'b1, 32'h10, 32'h00000011, 4'b0001, "st_byte0", rd);
        do_req(1'b0, 32'h10, 32'h0, 4'h0, "ld_byte0", rd);
        check("ld_byte0.value", rd, 32'hDEADBE11);

        // Misaligned and out-of-range errors, memory unchanged
        do_req(1'b0, 32'h13, 32'h0, 4'h0, "ld_misaligned", rd);
        do_req(1'b0, 32'h400, 32'h0, 4'h0, "ld_out_of_range", rd);
        do_req(1'b1, 32'h11, 32'hFFFFFFFF, 4'hF, "st_misaligned", rd);
        do_req(1'b0, 32'h10, 32'h0, 4'h0, "ld_unchanged", rd);
        check("ld_unchanged.value", rd, 32'hDEADBE11);

        // Store with no byte enables
        do_req(1'b1, 32'h24, 32'h12345678, 4'hF, "st_24", rd);
        do_req(1'b1, 32'h24, 32'hFFFFFFFF, 4'h0, "st_be0", rd);
        do_req(1'b0, 32'h24, 32'h0, 4'h0, "ld_be0", rd);
        check("ld_be0.value", rd, 32'h12345678);

        // Stores aborted by reset in WAIT and at the end of ACCESS
        abort_store(32'h20, 32'hCAFEF00D, 1, "abort_wait");
        do_req(1'b0, 32'h20, 32'h0, 4'h0, "ld_abort_wait", rd);
        check("ld_abort_wait.value", rd, 32'h0);
        abort_store(32'h20, 32'hCAFEF00D, 3, "abort_access");
        do_req(1'b0, 32'h20, 32'h0, 4'h0, "ld_abort_access", rd);
        check("ld_abort_access.value", rd, 32'h0);

        // Zero-wait instance with req_valid held high: one accept every 3 cycles
        @(negedge clk);
        z_req_valid = 1'b1;
        for (int n = 0; n < 12; n++) begin
            if (n > 0) @(negedge clk);
            check($sformatf("z_back2back.ready[%0d]", n), {31'b0, z_req_ready}, {31'b0, (n % 3) == 0});
            check($sformatf("z_back2back.valid[%0d]", n), {31'b0, z_rsp_valid}, {31'b0, (n % 3) == 2});
        end
        z_req_valid = 1'b0;
        $display("[TB] z_back2back 12 cycles with req_valid held high");

        // Randomized traffic against the model
        for (int t = 0; t < 40; t++) begin
            logic [31:0] a;
            logic        we;
            int          sel;
            sel = $urandom_range(0, 9);
            if (sel == 0) begin
                a = {22'($urandom_range(0, 255)), 8'h0} >> 6;
                a = {a[31:2], 2'($urandom_range(1, 3))};
            end else if (sel == 1) begin
                a = {30'($urandom_range(256, 100000)), 2'b00};
            end else begin
                a = {30'($urandom_range(0, 31)), 2'b00};
            end
            we = 1'($urandom);
            do_req(we, a, $urandom, 4'($urandom), $sformatf("rnd%0d", t), rd);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
